// File: rtl/muldiv_iter_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// XLEN/RLEN defaults mirror the register-file width (XBUS) and index width (R_MSB+1).
package muldiv_iter_pkg;

    localparam int unsigned MULDIV_XLEN = 32;
    localparam int unsigned MULDIV_RLEN = 5;

    typedef enum logic [2:0] {
        MULDIV_MUL    = 3'd0,
        MULDIV_MULH   = 3'd1,
        MULDIV_MULHSU = 3'd2,
        MULDIV_MULHU  = 3'd3,
        MULDIV_DIV    = 3'd4,
        MULDIV_DIVU   = 3'd5,
        MULDIV_REM    = 3'd6,
        MULDIV_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_WB   = 2'd3
    } muldiv_state_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op inside {MULDIV_DIV, MULDIV_DIVU, MULDIV_REM, MULDIV_REMU};
    endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Issue/write-back bundle between the pipeline and the multiply/divide unit.
interface muldiv_iter_if #(
    parameter int unsigned XLEN = muldiv_iter_pkg::MULDIV_XLEN,
    parameter int unsigned RLEN = muldiv_iter_pkg::MULDIV_RLEN
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [RLEN-1:0] rd;
    logic            kill;
    logic            ready;
    logic            busy;
    logic [RLEN-1:0] busy_rd;
    logic            wr_en;
    logic [RLEN-1:0] wr_addr;
    logic [XLEN-1:0] wr_data;

    modport master (
        output start, op, a, b, rd, kill,
        input  ready, busy, busy_rd, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, op, a, b, rd, kill,
        output ready, busy, busy_rd, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply / restoring divide over a shared hi:lo pair.
// hi:lo is the product after XLEN steps; for divide lo is the quotient and hi the remainder.
module muldiv_iter_core
    import muldiv_iter_pkg::*;
#(
    parameter int unsigned XLEN = MULDIV_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            cnt_zero_c
);

    localparam int unsigned CW = $clog2(XLEN);

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] addend;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_diff;
    logic [XLEN-1:0] hi_d;
    logic [XLEN-1:0] lo_d;

    assign cnt_zero_c = (cnt == '0);

    // Next hi:lo for one step; the borrow bit of rem_diff decides restore vs. keep.
    always_comb begin
        addend   = lo[0] ? opb : '0;
        mul_sum  = {1'b0, hi} + {1'b0, addend};
        rem_sh   = {hi, lo[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opb};
        hi_d     = hi;
        lo_d     = lo;
        if (is_div) begin
            if (!rem_diff[XLEN]) begin
                hi_d = rem_diff[XLEN-1:0];
                lo_d = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_d = rem_sh[XLEN-1:0];
                lo_d = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            {hi_d, lo_d} = {mul_sum, lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            opb <= '0;
            hi  <= '0;
            lo  <= '0;
        end else if (load) begin
            cnt <= CW'(XLEN - 1);
            opb <= b_mag;
            hi  <= '0;
            lo  <= a_mag;
        end else if (step) begin
            cnt <= cnt - CW'(1);
            hi  <= hi_d;
            lo  <= lo_d;
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit with register-file shaped write-back.
// Define MULDIV_EARLY_OUT_EN to let special cases and rd=0 skip the CALC phase.
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int unsigned XLEN = MULDIV_XLEN,
    parameter int unsigned RLEN = MULDIV_RLEN
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_iter_if.slave bus
);

    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e   state, state_d;
    muldiv_op_e      op_in, op_q;
    logic            accept, early, core_done;
    logic            a_neg, b_neg, a_sgn, b_sgn, neg_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, mul_zero, spec_vld_in;
    logic [XLEN-1:0] spec_res_in;
    logic [RLEN-1:0] rd_q;
    logic            neg_q, spec_vld_q;
    logic [XLEN-1:0] spec_res_q, res_q, fix_res;
    logic [XLEN-1:0] core_hi, core_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic            ready_d, busy_d, wr_en_d;
    logic [RLEN-1:0] busy_rd_d, wr_addr_d;
    logic [XLEN-1:0] wr_data_d;

    assign op_in  = muldiv_op_e'(bus.op);
    assign accept = (state == ST_IDLE) && bus.start && !bus.kill;

    // Operand magnitudes, result sign and special-case results evaluated at accept.
    always_comb begin
        a_neg = bus.a[XLEN-1];
        b_neg = bus.b[XLEN-1];
        a_sgn = op_in inside {MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM};
        b_sgn = op_in inside {MULDIV_MULH, MULDIV_DIV, MULDIV_REM};
        a_mag = (a_sgn && a_neg) ? -bus.a : bus.a;
        b_mag = (b_sgn && b_neg) ? -bus.b : bus.b;
        case (op_in)
            MULDIV_MULH, MULDIV_DIV:   neg_in = a_neg ^ b_neg;
            MULDIV_MULHSU, MULDIV_REM: neg_in = a_neg;
            default:                   neg_in = 1'b0;
        endcase
        div_zero    = op_is_div(op_in) && (bus.b == '0);
        div_ovf     = (op_in inside {MULDIV_DIV, MULDIV_REM}) && (bus.a == XMIN) && (bus.b == '1);
        mul_zero    = !op_is_div(op_in) && ((bus.a == '0) || (bus.b == '0));
        spec_vld_in = div_zero || div_ovf || mul_zero;
        spec_res_in = '0;
        if (div_zero) begin
            spec_res_in = bus.op[1] ? bus.a : '1;
        end else if (div_ovf) begin
            spec_res_in = bus.op[1] ? '0 : XMIN;
        end
`ifdef MULDIV_EARLY_OUT_EN
        early = spec_vld_in || (bus.rd == '0);
`else
        early = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= MULDIV_MUL;
            rd_q       <= '0;
            neg_q      <= 1'b0;
            spec_vld_q <= 1'b0;
            spec_res_q <= '0;
        end else if (accept) begin
            op_q       <= op_in;
            rd_q       <= bus.rd;
            neg_q      <= neg_in;
            spec_vld_q <= spec_vld_in;
            spec_res_q <= spec_res_in;
        end
    end

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .step       (state == ST_CALC),
        .is_div     (op_is_div(op_q)),
        .a_mag      (a_mag),
        .b_mag      (b_mag),
        .hi         (core_hi),
        .lo         (core_lo),
        .cnt_zero_c (core_done)
    );

    // Sign fix-up and result selection; the product is negated as a whole before taking a half.
    always_comb begin
        prod     = {core_hi, core_lo};
        prod_fix = neg_q ? -prod : prod;
        case (op_q)
            MULDIV_MUL:                              fix_res = prod_fix[XLEN-1:0];
            MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            MULDIV_DIV, MULDIV_DIVU:                 fix_res = neg_q ? -core_lo : core_lo;
            default:                                 fix_res = neg_q ? -core_hi : core_hi;
        endcase
        if (spec_vld_q) begin
            fix_res = spec_res_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (state == ST_FIX) begin
            res_q <= fix_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // kill overrides every transition, including the WB exit.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (accept) state_d = early ? ST_FIX : ST_CALC;
            ST_CALC: if (core_done) state_d = ST_FIX;
            ST_FIX:  state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.kill) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        ready_d   = (state_d == ST_IDLE);
        busy_d    = (state_d != ST_IDLE);
        busy_rd_d = '0;
        if (state_d != ST_IDLE) begin
            busy_rd_d = (state == ST_IDLE) ? bus.rd : rd_q;
        end
        wr_en_d   = (state == ST_WB) && !bus.kill && (rd_q != '0);
        wr_addr_d = wr_en_d ? rd_q  : bus.wr_addr;
        wr_data_d = wr_en_d ? res_q : bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ready   <= 1'b1;
            bus.busy    <= 1'b0;
            bus.busy_rd <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.ready   <= ready_d;
            bus.busy    <= busy_d;
            bus.busy_rd <= busy_rd_d;
            bus.wr_en   <= wr_en_d;
            bus.wr_addr <= wr_addr_d;
            bus.wr_data <= wr_data_d;
        end
    end

endmodule
